// File: rtl/memory_controller_pkg.sv
// Shared command codes, FSM state encoding and operation type for the
// byte-serial RAM command front end.
package memory_controller_pkg;

  localparam logic [7:0] COMMAND_WRITE = 8'h01;
  localparam logic [7:0] COMMAND_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEN      = 3'd1,
    ST_ADDR_HI  = 3'd2,
    ST_ADDR_LO  = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_RD_FETCH = 3'd5,
    ST_SEND     = 3'd6,
    ST_SEND_GAP = 3'd7
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

endpackage

// File: rtl/mc_ram.sv
// Single-port byte RAM: synchronous write, registered read, no reset.
module mc_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  // Read-during-write returns the previous contents.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_controller.sv
// Command front end between a UART receiver/transmitter pair and an on-chip
// RAM: parses CMD/LEN/ADDR frames and streams block writes or reads.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte
);

  state_t                state_reg;
  op_t                   op_reg;
  logic [7:0]            count_reg;
  logic [7:0]            addr_hi_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  ram_we;
  logic [7:0]            ram_rdata;

  assign ram_we = (state_reg == ST_WR_DATA) && received;

  mc_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (addr_reg),
    .wdata (rx_byte),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_WRITE;
      count_reg   <= 8'd0;
      addr_hi_reg <= 8'd0;
      addr_reg    <= '0;
      transmit    <= 1'b0;
      tx_byte     <= 8'd0;
    end else begin
      transmit <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (received && (rx_byte == COMMAND_WRITE || rx_byte == COMMAND_READ)) begin
            op_reg    <= (rx_byte == COMMAND_WRITE) ? OP_WRITE : OP_READ;
            state_reg <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (received) begin
            count_reg <= rx_byte;
            state_reg <= ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          if (received) begin
            addr_hi_reg <= rx_byte;
            state_reg   <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (received) begin
            // Address bits above the RAM depth are discarded here.
            addr_reg  <= ADDR_WIDTH'({addr_hi_reg, rx_byte});
            state_reg <= (op_reg == OP_WRITE) ? ST_WR_DATA : ST_RD_FETCH;
          end
        end
        ST_WR_DATA: begin
          if (received) begin
            addr_reg <= addr_reg + ADDR_WIDTH'(1);
            if (count_reg == 8'd0) begin
              state_reg <= ST_IDLE;
            end else begin
              count_reg <= count_reg - 8'd1;
            end
          end
        end
        ST_RD_FETCH: begin
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (!is_transmitting) begin
            transmit  <= 1'b1;
            tx_byte   <= ram_rdata;
            addr_reg  <= addr_reg + ADDR_WIDTH'(1);
            state_reg <= ST_SEND_GAP;
          end
        end
        ST_SEND_GAP: begin
          // The gap cycle guarantees transmit is never high two cycles running.
          if (count_reg == 8'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            count_reg <= count_reg - 8'd1;
            state_reg <= ST_RD_FETCH;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: directed frames plus randomized
// write/read-back blocks checked against a byte-array model of the RAM.
module tb_memory_controller;

  localparam int AW    = 12;
  localparam int DEPTH = 2**AW;

  logic       clock;
  logic       reset;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  int n_checks;
  int n_fail;

  logic [7:0] ref_mem [DEPTH];

  memory_controller #(.ADDR_WIDTH(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    received = 1'b0;
    rx_byte  = $urandom_range(0, 255);
  endtask

  task automatic write_frame(input logic [15:0] a, input logic [7:0] len,
                             input logic [7:0] data [256], input int max_gap);
    send_byte(8'h01);
    send_byte(len);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i <= int'(len); i++) begin
      send_byte(data[i]);
      ref_mem[(int'(a) + i) % DEPTH] = data[i];
      if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
    end
    $display("write addr=%04h len=%0d", a, len);
  endtask

  // Issues a read frame and checks every transmit pulse against the model.
  // After byte stall_at goes out, the transmitter reports busy for stall_len cycles.
  task automatic read_frame(input string name, input logic [15:0] a,
                            input logic [7:0] len, input int stall_at,
                            input int stall_len);
    int got, budget, busy_left;
    logic prev_tx;
    logic [7:0] exp;
    send_byte(8'h02);
    send_byte(len);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    got = 0;
    busy_left = 0;
    prev_tx = 1'b0;
    budget = (int'(len) + 1) * 3 + stall_len + 20;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (transmit) begin
        n_checks++;
        if (is_transmitting || prev_tx) begin
          n_fail++;
          $display("FAIL %s pulse_rule: busy=%0b prev=%0b required 0,0",
                   name, is_transmitting, prev_tx);
        end
        exp = ref_mem[(int'(a) + got) % DEPTH];
        n_checks++;
        if (got > int'(len)) begin
          n_fail++;
          $display("FAIL %s extra_byte: got %02h beyond %0d bytes", name, tx_byte, int'(len) + 1);
        end else if (tx_byte !== exp) begin
          n_fail++;
          $display("FAIL %s byte%0d: got %02h required %02h", name, got, tx_byte, exp);
        end
        got++;
      end
      prev_tx = transmit;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) is_transmitting = 1'b0;
      end else if (transmit && (got - 1) == stall_at && stall_len > 0) begin
        is_transmitting = 1'b1;
        busy_left = stall_len;
      end
    end
    is_transmitting = 1'b0;
    n_checks++;
    if (got != int'(len) + 1) begin
      n_fail++;
      $display("FAIL %s byte_count: got %0d required %0d", name, got, int'(len) + 1);
    end
    $display("read %s addr=%04h len=%0d bytes=%0d", name, a, len, got);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (transmit !== 1'b0 || tx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: transmit=%0b tx_byte=%02h required 0,00", transmit, tx_byte);
    end
    $display("reset transmit=%0b tx_byte=%02h", transmit, tx_byte);
  endtask

  task automatic test_basic();
    logic [7:0] d [256];
    d[0] = 8'h42; d[1] = 8'h43; d[2] = 8'h44;
    write_frame(16'h0ECD, 8'd2, d, 0);
    read_frame("basic", 16'h0ECD, 8'd2, -1, 0);
  endtask

  task automatic test_second_block();
    logic [7:0] d [256];
    d[0] = 8'h44; d[1] = 8'h45; d[2] = 8'h46;
    write_frame(16'h0A10, 8'd2, d, 1);
    read_frame("second", 16'h0A10, 8'd2, -1, 0);
    read_frame("reread", 16'h0ECD, 8'd2, -1, 0);
  endtask

  task automatic test_backpressure();
    read_frame("busy", 16'h0ECD, 8'd2, 0, 5);
  endtask

  task automatic test_unknown_cmd();
    send_byte(8'h7F);
    read_frame("after_7f", 16'h0A10, 8'd2, -1, 0);
  endtask

  task automatic test_wrap();
    logic [7:0] d [256];
    d[0] = 8'h11;
    write_frame(16'h0FFF, 8'd0, d, 0);
    d[0] = 8'hAA; d[1] = 8'hBB;
    write_frame(16'h0FFF, 8'd1, d, 0);
    n_checks++;
    if (ref_mem[0] !== 8'hBB) begin
      n_fail++;
      $display("FAIL wrap_model: got %02h required BB", ref_mem[0]);
    end
    read_frame("wrap0", 16'h0000, 8'd0, -1, 0);
    read_frame("wrap_fff", 16'hFFFF, 8'd1, -1, 0);
  endtask

  task automatic test_reset_abort();
    logic [7:0] d [256];
    d[0] = 8'h5A;
    write_frame(16'h0123, 8'd0, d, 0);
    read_frame("pre_abort", 16'h0123, 8'd0, -1, 0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h23);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (transmit !== 1'b0 || tx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_outputs: transmit=%0b tx_byte=%02h required 0,00", transmit, tx_byte);
    end
    send_byte(8'h99);
    read_frame("post_abort", 16'h0123, 8'd0, -1, 0);
  endtask

  task automatic test_random();
    logic [7:0] d [256];
    logic [15:0] a;
    logic [7:0] len;
    for (int it = 0; it < 8; it++) begin
      a   = 16'($urandom_range(0, 65535));
      len = 8'($urandom_range(0, 20));
      for (int i = 0; i < 256; i++) d[i] = 8'($urandom_range(0, 255));
      write_frame(a, len, d, 2);
      read_frame("random", a, len, $urandom_range(0, int'(len)), $urandom_range(0, 6));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    received = 1'b0;
    rx_byte = 8'h00;
    is_transmitting = 1'b0;
    test_reset();
    test_basic();
    test_second_block();
    test_backpressure();
    test_unknown_cmd();
    test_wrap();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
